// File: rtl/trace_arbiter.sv
// Round-robin arbiter feeding the shared trace-buffer write port from NSRC one-entry source slots,
// with a stop/post-trigger capture FSM and per-source saturating drop counters.
module trace_arbiter #(
  parameter int NSRC       = 5,
  parameter int Fpay       = 32,
  parameter int SRCw       = 3,
  parameter int DCw        = 8,
  parameter int POST_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSRC-1:0]      trigger_all,
  input  logic [NSRC*Fpay-1:0] trace_all,
  input  logic [NSRC-1:0]      src_en,
  input  logic [NSRC-1:0]      stop_mask,
  input  logic                 arm,
  input  logic                 tb_ready,
  output logic                 tb_wr,
  output logic [Fpay-1:0]      tb_dout,
  output logic [SRCw-1:0]      tb_src,
  output logic [1:0]           state_o,
  output logic [NSRC*DCw-1:0]  drop_cnt_all,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [DCw-1:0] DC_MAX = {DCw{1'b1}};

  state_e          state_q, state_d;
  logic [NSRC-1:0] slot_full_q, slot_full_d;
  logic [Fpay-1:0] slot_data_q [NSRC];
  logic [Fpay-1:0] slot_data_d [NSRC];
  logic [SRCw-1:0] rr_q, rr_d;
  logic [7:0]      post_cnt_q, post_cnt_d;
  logic [DCw-1:0]  drop_cnt_q [NSRC];
  logic [DCw-1:0]  drop_cnt_d [NSRC];
  logic            overflow_q, overflow_d;
  logic            tb_wr_q, tb_wr_d;
  logic [Fpay-1:0] tb_dout_q, tb_dout_d;
  logic [SRCw-1:0] tb_src_q, tb_src_d;

  logic            out_free_s;
  logic            active_s;
  logic            grant_s;
  logic            gnt_found_s;
  logic [SRCw-1:0] gnt_idx_s;
  logic [SRCw-1:0] cand_s;

  // Pick the first full slot at or after the round-robin pointer, wrapping modulo NSRC.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = {SRCw{1'b0}};
    cand_s      = {SRCw{1'b0}};
    for (int k = 0; k < NSRC; k++) begin
      cand_s = SRCw'((32'(rr_q) + 32'(k)) % NSRC);
      if (!gnt_found_s && slot_full_q[cand_s]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = cand_s;
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  // Next-state logic for slots, output register, drop counters and capture FSM.
  always_comb begin
    state_d     = state_q;
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    rr_d        = rr_q;
    post_cnt_d  = post_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    overflow_d  = overflow_q;
    tb_wr_d     = tb_wr_q;
    tb_dout_d   = tb_dout_q;
    tb_src_d    = tb_src_q;

    out_free_s = !tb_wr_q || tb_ready;
    active_s   = (state_q == RUN) || (state_q == POST);
    // An arm cycle discards slot contents, so nothing is granted from them.
    grant_s    = out_free_s && gnt_found_s && active_s && !arm;

    if (grant_s) begin
      tb_wr_d                = 1'b1;
      tb_dout_d              = slot_data_q[gnt_idx_s];
      tb_src_d               = gnt_idx_s;
      slot_full_d[gnt_idx_s] = 1'b0;
      rr_d = (gnt_idx_s == SRCw'(NSRC - 1)) ? {SRCw{1'b0}} : gnt_idx_s + SRCw'(1);
    end else if (out_free_s) begin
      tb_wr_d = 1'b0;
    end else begin
      tb_wr_d = tb_wr_q;
    end

    for (int i = 0; i < NSRC; i++) begin
      if (active_s && !arm && trigger_all[i] && src_en[i]) begin
        if (!slot_full_q[i] || (grant_s && (gnt_idx_s == SRCw'(i)))) begin
          slot_full_d[i] = 1'b1;
          slot_data_d[i] = trace_all[i*Fpay +: Fpay];
        end else begin
          drop_cnt_d[i] = (drop_cnt_q[i] == DC_MAX) ? DC_MAX : drop_cnt_q[i] + DCw'(1);
          overflow_d    = 1'b1;
        end
      end else begin
        slot_full_d[i] = slot_full_d[i];
      end
    end

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      RUN: begin
        if (grant_s && stop_mask[gnt_idx_s]) begin
          state_d    = POST;
          post_cnt_d = 8'(POST_DEPTH);
        end else begin
          state_d = RUN;
        end
      end
      POST: begin
        if (grant_s) begin
          post_cnt_d = post_cnt_q - 8'd1;
          state_d    = (post_cnt_q == 8'd1) ? DONE : POST;
        end else begin
          state_d = POST;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // arm restarts capture from any state; the output word and rr pointer survive.
    if (arm) begin
      state_d     = RUN;
      slot_full_d = {NSRC{1'b0}};
      overflow_d  = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        drop_cnt_d[i] = {DCw{1'b0}};
      end
    end else begin
      state_d = state_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      slot_full_q <= {NSRC{1'b0}};
      rr_q        <= {SRCw{1'b0}};
      post_cnt_q  <= 8'd0;
      overflow_q  <= 1'b0;
      tb_wr_q     <= 1'b0;
      tb_dout_q   <= {Fpay{1'b0}};
      tb_src_q    <= {SRCw{1'b0}};
      for (int i = 0; i < NSRC; i++) begin
        slot_data_q[i] <= {Fpay{1'b0}};
        drop_cnt_q[i]  <= {DCw{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      slot_full_q <= slot_full_d;
      rr_q        <= rr_d;
      post_cnt_q  <= post_cnt_d;
      overflow_q  <= overflow_d;
      tb_wr_q     <= tb_wr_d;
      tb_dout_q   <= tb_dout_d;
      tb_src_q    <= tb_src_d;
      for (int i = 0; i < NSRC; i++) begin
        slot_data_q[i] <= slot_data_d[i];
        drop_cnt_q[i]  <= drop_cnt_d[i];
      end
    end
  end

  assign tb_wr    = tb_wr_q;
  assign tb_dout  = tb_dout_q;
  assign tb_src   = tb_src_q;
  assign state_o  = state_q;
  assign overflow = overflow_q;

  for (genvar g = 0; g < NSRC; g++) begin : g_drop_out
    assign drop_cnt_all[g*DCw +: DCw] = drop_cnt_q[g];
  end

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed self-checking bench for trace_arbiter: latency, round-robin order, backpressure,
// drop-counter saturation, stop/post capture and asynchronous reset.
module tb_trace_arbiter;

  localparam int NSRC = 5;
  localparam int Fpay = 32;
  localparam int SRCw = 3;
  localparam int DCw  = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NSRC-1:0]      trigger_all;
  logic [NSRC*Fpay-1:0] trace_all;
  logic [NSRC-1:0]      src_en;
  logic [NSRC-1:0]      stop_mask;
  logic                 arm;
  logic                 tb_ready;
  logic                 tb_wr;
  logic [Fpay-1:0]      tb_dout;
  logic [SRCw-1:0]      tb_src;
  logic [1:0]           state_o;
  logic [NSRC*DCw-1:0]  drop_cnt_all;
  logic                 overflow;

  int n_checks = 0;
  int n_fail   = 0;

  trace_arbiter #(
    .NSRC(NSRC), .Fpay(Fpay), .SRCw(SRCw), .DCw(DCw), .POST_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .trigger_all(trigger_all), .trace_all(trace_all),
    .src_en(src_en), .stop_mask(stop_mask), .arm(arm), .tb_ready(tb_ready),
    .tb_wr(tb_wr), .tb_dout(tb_dout), .tb_src(tb_src), .state_o(state_o),
    .drop_cnt_all(drop_cnt_all), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int src, input logic [31:0] w);
    trace_all[src*Fpay +: Fpay] = w;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    trigger_all = '0;
    trace_all   = '0;
    src_en      = '1;
    stop_mask   = '0;
    arm         = 1'b0;
    tb_ready    = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    int seen_stop;
    int post_writes;
    int stray;

    // Reset values
    do_reset();
    check_eq("rst_wr", 64'(tb_wr), 64'd0);
    check_eq("rst_dout", 64'(tb_dout), 64'd0);
    check_eq("rst_src", 64'(tb_src), 64'd0);
    check_eq("rst_state", 64'(state_o), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt_all), 64'd0);
    check_eq("rst_ovf", 64'(overflow), 64'd0);

    // Single trigger latency on source 2
    pulse_arm();
    check_eq("arm_state", 64'(state_o), 64'd1);
    trigger_all[2] = 1'b1;
    set_word(2, 32'hA5A5_0002);
    tick();
    trigger_all = '0;
    check_eq("lat_wr_early", 64'(tb_wr), 64'd0);
    tick();
    check_eq("lat_wr", 64'(tb_wr), 64'd1);
    check_eq("lat_dout", 64'(tb_dout), 64'hA5A5_0002);
    check_eq("lat_src", 64'(tb_src), 64'd2);
    tick();
    check_eq("lat_wr_after", 64'(tb_wr), 64'd0);

    // Round-robin order with all sources, then 0 and 4
    do_reset();
    pulse_arm();
    for (int i = 0; i < NSRC; i++) set_word(i, 32'hC0DE_0000 + 32'(i));
    trigger_all = 5'b11111;
    tick();
    trigger_all = '0;
    for (int i = 0; i < NSRC; i++) begin
      tick();
      check_eq("rr_wr", 64'(tb_wr), 64'd1);
      check_eq("rr_src", 64'(tb_src), 64'(i));
      check_eq("rr_dout", 64'(tb_dout), 64'hC0DE_0000 + 64'(i));
    end
    trigger_all = 5'b10001;
    tick();
    trigger_all = '0;
    tick();
    check_eq("rr04_first", 64'(tb_src), 64'd0);
    tick();
    check_eq("rr04_second", 64'(tb_src), 64'd4);
    check_eq("rr04_wr", 64'(tb_wr), 64'd1);
    tick();
    check_eq("rr04_idle", 64'(tb_wr), 64'd0);

    // Backpressure on source 1
    do_reset();
    pulse_arm();
    tb_ready = 1'b0;
    trigger_all[1] = 1'b1;
    set_word(1, 32'h1111_0001);
    tick();
    set_word(1, 32'h1111_0002);
    tick();
    set_word(1, 32'h1111_0003);
    tick();
    set_word(1, 32'h1111_0004);
    tick();
    trigger_all = '0;
    for (int k = 0; k < 7; k++) begin
      check_eq("bp_wr", 64'(tb_wr), 64'd1);
      check_eq("bp_dout", 64'(tb_dout), 64'h1111_0001);
      check_eq("bp_src", 64'(tb_src), 64'd1);
      tick();
    end
    check_eq("bp_drop1", 64'(drop_cnt_all[1*DCw +: DCw]), 64'd2);
    check_eq("bp_drop_others", 64'(drop_cnt_all & ~(40'hFF << DCw)), 64'd0);
    check_eq("bp_ovf", 64'(overflow), 64'd1);
    tb_ready = 1'b1;
    tick();
    check_eq("bp_drain_wr", 64'(tb_wr), 64'd1);
    check_eq("bp_drain_dout", 64'(tb_dout), 64'h1111_0002);
    tick();
    check_eq("bp_drain_done", 64'(tb_wr), 64'd0);

    // Drop counter saturation and src_en gating on source 3
    do_reset();
    pulse_arm();
    tb_ready = 1'b0;
    set_word(3, 32'h3333_3333);
    trigger_all[3] = 1'b1;
    repeat (12) tick();
    check_eq("sat_drop10", 64'(drop_cnt_all[3*DCw +: DCw]), 64'd10);
    src_en[3] = 1'b0;
    repeat (5) tick();
    check_eq("sat_en_off", 64'(drop_cnt_all[3*DCw +: DCw]), 64'd10);
    src_en[3] = 1'b1;
    repeat (290) tick();
    check_eq("sat_255", 64'(drop_cnt_all[3*DCw +: DCw]), 64'd255);
    src_en[3] = 1'b0;
    repeat (3) tick();
    check_eq("sat_hold", 64'(drop_cnt_all[3*DCw +: DCw]), 64'd255);
    trigger_all = '0;
    src_en = '1;

    // Stop path with POST_DEPTH=4 and stop on source 4
    do_reset();
    stop_mask = 5'b10000;
    pulse_arm();
    set_word(0, 32'h0000_00A0);
    set_word(4, 32'h0000_00A4);
    trigger_all = 5'b10001;
    seen_stop   = 0;
    post_writes = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (tb_wr) begin
        if (seen_stop != 0) post_writes++;
        else if (tb_src == 3'd4) seen_stop = 1;
      end
    end
    check_eq("stop_seen", 64'(seen_stop), 64'd1);
    check_eq("stop_post_writes", 64'(post_writes), 64'd4);
    check_eq("stop_state_done", 64'(state_o), 64'd3);
    check_eq("stop_wr_idle", 64'(tb_wr), 64'd0);
    check_eq("stop_ovf", 64'(overflow), 64'd1);
    trigger_all = '0;
    pulse_arm();
    check_eq("rearm_state", 64'(state_o), 64'd1);
    check_eq("rearm_drop", 64'(drop_cnt_all), 64'd0);
    check_eq("rearm_ovf", 64'(overflow), 64'd0);

    // Asynchronous reset mid-drain
    do_reset();
    pulse_arm();
    tb_ready = 1'b0;
    trigger_all = 5'b00111;
    tick();
    trigger_all = 5'b00001;
    tick();
    trigger_all = '0;
    check_eq("ar_pre_wr", 64'(tb_wr), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_wr", 64'(tb_wr), 64'd0);
    check_eq("ar_state", 64'(state_o), 64'd0);
    #1;
    reset = 1'b1;
    tb_ready = 1'b1;
    trigger_all = 5'b11111;
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (tb_wr) stray++;
    end
    trigger_all = '0;
    check_eq("ar_no_output", 64'(stray), 64'd0);
    check_eq("ar_state_idle", 64'(state_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_arbiter.md
Name: trace_arbiter

Overview:
- Shares the single trace buffer write port between the NSRC trace sources (4 tiles plus the NoC).
- Replaces the fixed-priority trigger/trace mux that sits in front of the trace buffer.
- Each source gets a one-entry holding slot. A round-robin arbiter drains the slots into a registered valid/ready output.
- A capture FSM stops tracing POST_DEPTH writes after a stop-source event, and per-source drop counters expose lost events.

Parameters:
- NSRC, 5, number of trace sources; source 4 is the NoC.
- Fpay, 32, trace word width.
- SRCw, 3, source-id width; must satisfy 2**SRCw >= NSRC.
- DCw, 8, width of each per-source drop counter.
- POST_DEPTH, 16, number of writes accepted after the stop event; range 1..255.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-low reset; 0 = reset asserted.
- trigger_all, in, NSRC: per-source trace strobe; bit i belongs to source i.
- trace_all, in, NSRC*Fpay: per-source trace words; source i occupies [(i+1)*Fpay-1 : i*Fpay].
- src_en, in, NSRC: per-source enable; a disabled source's triggers are ignored and not counted.
- stop_mask, in, NSRC: sources whose granted entry starts the post-trigger phase.
- arm, in, 1: single-cycle pulse that (re)starts capture.
- tb_ready, in, 1: trace buffer accepts a word this cycle.
- tb_wr, out, 1: output word valid.
- tb_dout, out, Fpay: output trace word.
- tb_src, out, SRCw: source id of tb_dout.
- state_o, out, 2: FSM state; IDLE=0, RUN=1, POST=2, DONE=3.
- drop_cnt_all, out, NSRC*DCw: per-source saturating drop counters.
- overflow, out, 1: sticky; set when any drop occurs.

Behaviour:
- Reset (reset=0), asynchronous:
  - tb_wr=0, tb_dout=0, tb_src=0.
  - state=IDLE, all slots empty, rr pointer=0, post counter=0.
  - drop counters=0, overflow=0.
- Slot capture:
  - Condition: trigger_all[i] & src_en[i] & state in {RUN,POST}.
  - If slot i is empty, or is being granted this cycle, trace word i is loaded and the slot is marked full at the edge.
  - Otherwise the event is dropped: drop_cnt[i] increments, saturating at 2**DCw-1, and overflow is set.
- Output register:
  - out_free = !tb_wr | tb_ready.
  - When out_free and any slot is full, the arbiter grants the first full slot at or after the rr pointer, wrapping modulo NSRC.
  - On grant, at the edge: tb_dout and tb_src load from slot g, tb_wr=1, slot g clears, rr pointer becomes (g+1) mod NSRC.
  - When out_free and no slot is full, tb_wr goes to 0.
  - While tb_wr=1 and tb_ready=0, tb_wr, tb_dout and tb_src hold stable.
- Latency: a trigger at edge t fills the slot; with no contention, tb_wr=1 in the cycle after edge t+1, i.e. 2 cycles after the trigger is sampled.
- Throughput: one word per cycle while tb_ready=1.
- FSM:
  - IDLE -> RUN on arm.
  - RUN -> POST when a grant comes from a source with stop_mask[g]=1; post counter loads POST_DEPTH.
    - The stop entry itself is written and is not counted in POST_DEPTH.
  - POST: each subsequent grant decrements the counter. The grant that brings it to 0 moves the FSM to DONE.
  - DONE: no captures and no grants. An already-registered output word is still presented until accepted.
  - arm in RUN, POST or DONE:
    - FSM goes to RUN.
    - All slots clear; any pending slot contents are discarded.
    - Drop counters and overflow clear; the rr pointer is retained.
    - arm does not cancel a held output word.
  - A trigger in the same cycle as arm is ignored.
- Reset mid-operation discards all slots and any output word immediately.

Test Plan:
- Reset, then arm, then a single trigger on source 2 with trace=0xA5A5_0002 and tb_ready=1 -> tb_wr=1 with tb_dout=0xA5A5_0002 and tb_src=2 exactly 2 cycles after the trigger; tb_wr=0 in the following cycle.
- All 5 sources trigger in one cycle after arm -> tb_src sequence 0,1,2,3,4 on 5 consecutive cycles. Then repeat with sources 0 and 4 only -> order 0,4.
- Backpressure: tb_ready=0 for 10 cycles with slot 1 pending and source 1 triggering 3 more times -> output word stable throughout; drop_cnt[1]=2, overflow=1. After tb_ready=1, the first held word and then the second word drain.
- Saturation: DCw=8 and 300 drops on source 3 -> drop_cnt[3]=255. src_en[3]=0 -> further triggers leave the count unchanged.
- Stop path: POST_DEPTH=4, stop_mask=5'b10000, continuous triggers on sources 0 and 4 -> after the first tb_src=4 write, exactly 4 more writes occur, then state_o=3 and tb_wr stays 0. A subsequent arm -> state_o=1 and drop_cnt_all=0.
- Assert reset=0 mid-drain with 3 slots full -> tb_wr=0 immediately with no clock edge needed, state_o=0. After release without arm -> no output despite triggers.
